// File: rtl/regfile_access_ctrl_if.sv
// Bundle of the decode-issue, ALU-operand, writeback and register-file signals
// seen by the register-file access controller.
//
// Handshakes: a transfer on iss_* or op_* happens on a rising clk edge where
// valid and ready are both high. A valid source holds its payload stable and
// keeps valid asserted until that edge, and ready never depends on the payload.
// wb_* has no ready: every cycle with wb_valid high is taken.
interface regfile_access_ctrl_if #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int STALL_CNT_W = 8
);
    logic                   iss_valid;
    logic                   iss_ready;
    logic [ADDR_W-1:0]      iss_rs1;
    logic [ADDR_W-1:0]      iss_rs2;
    logic [ADDR_W-1:0]      iss_rd;
    logic                   iss_rd_en;

    logic                   op_valid;
    logic                   op_ready;
    logic [DATA_W-1:0]      op_a;
    logic [DATA_W-1:0]      op_b;
    logic [ADDR_W-1:0]      op_rd;
    logic                   op_rd_en;

    logic                   wb_valid;
    logic [ADDR_W-1:0]      wb_rd;
    logic [DATA_W-1:0]      wb_data;

    logic                   rf_reg_write;
    logic [ADDR_W-1:0]      rf_write_reg;
    logic [DATA_W-1:0]      rf_write_data;
    logic [ADDR_W-1:0]      rf_read_reg1;
    logic [ADDR_W-1:0]      rf_read_reg2;
    logic [DATA_W-1:0]      rf_read_data1;
    logic [DATA_W-1:0]      rf_read_data2;

    logic [STALL_CNT_W-1:0] stall_cnt;

    // Controller side
    modport master (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        output iss_ready,
        output op_valid, op_a, op_b, op_rd, op_rd_en,
        input  op_ready,
        input  wb_valid, wb_rd, wb_data,
        output rf_reg_write, rf_write_reg, rf_write_data, rf_read_reg1, rf_read_reg2,
        input  rf_read_data1, rf_read_data2,
        output stall_cnt
    );

    // Decode / ALU / register-file side
    modport slave (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        input  iss_ready,
        input  op_valid, op_a, op_b, op_rd, op_rd_en,
        output op_ready,
        output wb_valid, wb_rd, wb_data,
        input  rf_reg_write, rf_write_reg, rf_write_data, rf_read_reg1, rf_read_reg2,
        output rf_read_data1, rf_read_data2,
        input  stall_cnt
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: accepts one instruction at a time, waits in
// FETCH until no source or destination is pending in the busy scoreboard, then
// captures both operands (with same-cycle writeback forwarding) and holds them
// for the ALU stage. The writeback port is passed straight to the file.
module regfile_access_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int STALL_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_access_ctrl_if.master      bus,
    output logic [1:0]                 dbg_state_o,
    output logic [(1 << ADDR_W)-1:0]   dbg_busy_o
);
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      rs1_q, rs2_q, rd_q;
    logic                   rd_en_q;
    logic [NREGS-1:0]       busy_q, busy_d;
    logic [DATA_W-1:0]      op_a_q, op_b_q;
    logic [ADDR_W-1:0]      op_rd_q;
    logic                   op_rd_en_q;
    logic                   op_valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic accept, op_fire;
    logic wb_hit1, wb_hit2, wb_hit_rd;
    logic blocked, fetch_go;

    assign accept    = bus.iss_valid & bus.iss_ready;
    assign op_fire   = op_valid_q & bus.op_ready;
    assign wb_hit1   = bus.wb_valid && (bus.wb_rd == rs1_q);
    assign wb_hit2   = bus.wb_valid && (bus.wb_rd == rs2_q);
    assign wb_hit_rd = bus.wb_valid && (bus.wb_rd == rd_q);
    // A writeback landing this cycle releases its register immediately.
    assign blocked   = (busy_q[rs1_q] & ~wb_hit1) |
                       (busy_q[rs2_q] & ~wb_hit2) |
                       (rd_en_q & busy_q[rd_q] & ~wb_hit_rd);
    assign fetch_go  = (state_q == S_FETCH) && !blocked;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> FETCH -> HOLD -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)   state_d = S_FETCH;
            S_FETCH: if (!blocked) state_d = S_HOLD;
            S_HOLD:  if (op_fire)  state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake, operand bundle, file ports, debug view
    always_comb begin
        bus.iss_ready     = (state_q == S_IDLE);
        bus.op_valid      = op_valid_q;
        bus.op_a          = op_a_q;
        bus.op_b          = op_b_q;
        bus.op_rd         = op_rd_q;
        bus.op_rd_en      = op_rd_en_q;
        bus.rf_reg_write  = bus.wb_valid & ~rst;
        bus.rf_write_reg  = bus.wb_rd;
        bus.rf_write_data = bus.wb_data;
        bus.rf_read_reg1  = rs1_q;
        bus.rf_read_reg2  = rs2_q;
        bus.stall_cnt     = stall_cnt_q;
        dbg_state_o       = state_q;
        dbg_busy_o        = busy_q;
    end

    // Scoreboard update: clear on writeback, set on issue; set is applied last so it wins
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid)
            busy_d[bus.wb_rd] = 1'b0;
        if (fetch_go && rd_en_q)
            busy_d[rd_q] = 1'b1;
    end

    // Instruction latch, operand capture, scoreboard and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_rd_q     <= '0;
            op_rd_en_q  <= 1'b0;
            op_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                rs1_q   <= bus.iss_rs1;
                rs2_q   <= bus.iss_rs2;
                rd_q    <= bus.iss_rd;
                rd_en_q <= bus.iss_rd_en;
            end
            if (fetch_go) begin
                // Forward even when not busy: the file has not committed this write yet.
                op_a_q     <= wb_hit1 ? bus.wb_data : bus.rf_read_data1;
                op_b_q     <= wb_hit2 ? bus.wb_data : bus.rf_read_data2;
                op_rd_q    <= rd_q;
                op_rd_en_q <= rd_en_q;
                op_valid_q <= 1'b1;
            end else if (op_fire) begin
                op_valid_q <= 1'b0;
            end
            if ((state_q == S_FETCH) && blocked && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + STALL_ONE;
        end
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios followed by random
// instructions, checked against an array-based model of the file and scoreboard.
module tb_regfile_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.DATA_W(8), .ADDR_W(3), .STALL_CNT_W(8)) bus ();
    logic [1:0] dbg_state;
    logic [7:0] dbg_busy;

    regfile_access_ctrl #(.DATA_W(8), .ADDR_W(3), .STALL_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_busy_o  (dbg_busy)
    );

    // Register file environment: combinational read, write on clock edge
    logic [7:0] rf_mem [8];
    assign bus.rf_read_data1 = rf_mem[bus.rf_read_reg1];
    assign bus.rf_read_data2 = rf_mem[bus.rf_read_reg2];
    always @(posedge clk) if (bus.rf_reg_write) rf_mem[bus.rf_write_reg] <= bus.rf_write_data;

    // Reference model state
    logic [7:0] ref_mem [8];
    logic [7:0] ref_busy;
    int         ref_stall;
    logic [2:0] p_rs1, p_rs2, p_rd;
    logic       p_rd_en;
    logic [7:0] exp_a, exp_b;

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 3'd5;
        bus.wb_data  = 8'hAA;
        #1;
        check("rst_rf_we_blocked", bus.rf_reg_write, 0);
        step();
        step();
        check("rst_rf_we_blocked2", bus.rf_reg_write, 0);
        rst          = 1'b0;
        bus.wb_valid = 1'b0;
        step();
        ref_busy  = '0;
        ref_stall = 0;
        check("rst_iss_ready", bus.iss_ready, 1);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_busy", dbg_busy, 0);
        check("rst_op_a", bus.op_a, 0);
        check("rst_op_rd_en", bus.op_rd_en, 0);
        check("rst_read_reg1", bus.rf_read_reg1, 0);
    endtask

    // Writeback while the controller is idle
    task automatic idle_wb(input logic [2:0] r, input logic [7:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        bus.wb_data  = d;
        #1;
        check("wb_rf_we", bus.rf_reg_write, 1);
        check("wb_rf_wreg", bus.rf_write_reg, r);
        check("wb_rf_wdata", bus.rf_write_data, d);
        step();
        bus.wb_valid = 1'b0;
        ref_mem[r]   = d;
        ref_busy[r]  = 1'b0;
        check("wb_busy", dbg_busy, ref_busy);
    endtask

    task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic rd_en);
        check("iss_ready_idle", bus.iss_ready, 1);
        bus.iss_valid = 1'b1;
        bus.iss_rs1   = rs1;
        bus.iss_rs2   = rs2;
        bus.iss_rd    = rd;
        bus.iss_rd_en = rd_en;
        step();
        bus.iss_valid = 1'b0;
        check("iss_ready_busy", bus.iss_ready, 0);
        check("op_valid_after_accept", bus.op_valid, 0);
        p_rs1 = rs1; p_rs2 = rs2; p_rd = rd; p_rd_en = rd_en;
    endtask

    // One FETCH cycle with an optional writeback; model decides stall vs capture
    task automatic fetch_step(input logic w, input logic [2:0] wr, input logic [7:0] wd,
                              output bit done);
        logic h1, h2, hd, blk;
        bus.wb_valid = w;
        bus.wb_rd    = wr;
        bus.wb_data  = wd;
        h1  = w && (wr == p_rs1);
        h2  = w && (wr == p_rs2);
        hd  = w && (wr == p_rd);
        blk = (ref_busy[p_rs1] && !h1) || (ref_busy[p_rs2] && !h2) ||
              (p_rd_en && ref_busy[p_rd] && !hd);
        if (!blk) begin
            exp_a = h1 ? wd : ref_mem[p_rs1];
            exp_b = h2 ? wd : ref_mem[p_rs2];
        end
        if (w) begin
            ref_mem[wr]  = wd;
            ref_busy[wr] = 1'b0;
        end
        if (!blk && p_rd_en) ref_busy[p_rd] = 1'b1;
        if (blk && ref_stall < 255) ref_stall++;
        step();
        bus.wb_valid = 1'b0;
        check("fetch_op_valid", bus.op_valid, !blk);
        if (!blk) begin
            check("fetch_op_a", bus.op_a, exp_a);
            check("fetch_op_b", bus.op_b, exp_b);
            check("fetch_op_rd", bus.op_rd, p_rd);
            check("fetch_op_rd_en", bus.op_rd_en, p_rd_en);
        end
        check("fetch_stall_cnt", bus.stall_cnt, ref_stall);
        check("fetch_busy", dbg_busy, ref_busy);
        done = !blk;
    endtask

    task automatic release_hold(input int waits);
        for (int i = 0; i < waits; i++) begin
            bus.op_ready = 1'b0;
            step();
            check("hold_op_valid", bus.op_valid, 1);
            check("hold_op_a", bus.op_a, exp_a);
            check("hold_op_b", bus.op_b, exp_b);
            check("hold_op_rd", bus.op_rd, p_rd);
            check("hold_iss_ready", bus.iss_ready, 0);
        end
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check("release_op_valid", bus.op_valid, 0);
        check("release_iss_ready", bus.iss_ready, 1);
    endtask

    initial begin
        bit         done;
        int         n;
        logic       w;
        logic [2:0] wr;

        rst           = 1'b1;
        bus.iss_valid = 1'b0;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        bus.iss_rd    = '0;
        bus.iss_rd_en = 1'b0;
        bus.op_ready  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        ref_busy      = '0;
        ref_stall     = 0;

        // Reset behaviour
        do_reset();
        for (int r = 0; r < 8; r++) idle_wb(3'(r), 8'($urandom_range(0, 255)));

        // Writeback then issue reading it on both ports
        idle_wb(3'd6, 8'hFA);
        issue(3'd6, 3'd6, 3'd1, 1'b1);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        check("t2_done", done, 1);
        check("t2_op_a_const", bus.op_a, 8'hFA);
        check("t2_op_b_const", bus.op_b, 8'hFA);
        check("t2_busy1", dbg_busy[1], 1);
        release_hold(0);

        // RAW stall with forwarded writeback
        issue(3'd0, 3'd0, 3'd3, 1'b1);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        release_hold(0);
        issue(3'd3, 3'd0, 3'd5, 1'b0);
        for (int i = 0; i < 3; i++) fetch_step(1'b0, 3'd0, 8'h00, done);
        check("t3_still_stalled", done, 0);
        check("t3_stall3", bus.stall_cnt, 3);
        fetch_step(1'b1, 3'd3, 8'h5C, done);
        check("t3_op_a_fwd", bus.op_a, 8'h5C);
        check("t3_busy3_clear", dbg_busy[3], 0);

        // Long hold with ALU not ready
        release_hold(5);

        // WAW stall; set wins over same-cycle clear
        issue(3'd0, 3'd0, 3'd2, 1'b1);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        release_hold(0);
        issue(3'd4, 3'd5, 3'd2, 1'b1);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        check("t5_waw_stalled", done, 0);
        fetch_step(1'b1, 3'd2, 8'h77, done);
        check("t5_waw_done", done, 1);
        check("t5_busy2_set", dbg_busy[2], 1);
        release_hold(1);

        // Stall counter saturation
        issue(3'd2, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 260; i++) fetch_step(1'b0, 3'd0, 8'h00, done);
        check("sat_stall_cnt", bus.stall_cnt, 8'hFF);
        fetch_step(1'b1, 3'd2, 8'h3C, done);
        check("sat_done", done, 1);
        release_hold(0);

        // Reset while stalled in FETCH
        issue(3'd1, 3'd1, 3'd4, 1'b1);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        fetch_step(1'b0, 3'd0, 8'h00, done);
        rst = 1'b1;
        step();
        check("t6_state_idle", dbg_state, 0);
        check("t6_busy_clear", dbg_busy, 0);
        check("t6_op_valid", bus.op_valid, 0);
        check("t6_stall_cnt", bus.stall_cnt, 0);
        rst       = 1'b0;
        ref_busy  = '0;
        ref_stall = 0;
        step();
        check("t6_iss_ready", bus.iss_ready, 1);

        // Random instructions with random writebacks during FETCH
        for (int k = 0; k < 40; k++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            done = 0;
            n    = 0;
            while (!done && n < 300) begin
                w  = 1'($urandom_range(0, 1));
                wr = 3'($urandom_range(0, 7));
                if (ref_busy != 0)
                    while (!ref_busy[wr]) wr = 3'($urandom_range(0, 7));
                fetch_step(w, wr, 8'($urandom_range(0, 255)), done);
                n++;
            end
            if (!done) begin
                check("rand_fetch_timeout", 0, 1);
                do_reset();
            end else begin
                release_hold($urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
